frame_read_mc: RTL and testbench

//  Parametrised multi-buffer frame reader: streams frames out of NUM_BUFS SDRAM frame buffers via Avalon-MM burst reads.

---
 rtl/frame_read_mc.sv | 171 +++++++++++++++++
 tb/tb_frame_read_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_mc.sv
// frame_read_mc: rotating multi-buffer frame reader, Avalon-MM burst master feeding a FWFT pixel FIFO.
// Define FRAME_READ_SOF_EN to add the out_sof start-of-frame tag output.
module frame_read_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_BUFS = 4,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 32'h0020_0000,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN = 128,
  parameter int FIFO_DEPTH = 512,
  localparam int BUF_W = $clog2(NUM_BUFS),
  localparam int BC_W = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rest_n,
  input  logic              frame_restart,
  input  logic [BUF_W-1:0]  occupy_write,
  input  logic [BUF_W-1:0]  occupy_shot,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  cur_buf
`ifdef FRAME_READ_SOF_EN
  ,
  output logic              out_sof
`endif
);

  localparam int WO_W = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + 2;
`ifdef FRAME_READ_SOF_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t            state, state_n;
  logic [WO_W-1:0]   word_ofs, remaining;
  logic [BC_W-1:0]   blen;
  logic [CNT_W-1:0]  outstanding, outstanding_n, fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]     push_word, head;
  logic [ADDR_W-1:0] issue_addr;
  logic [BUF_W-1:0]  next_buf, walk_buf;
  logic              walk_done, credit_ok, accept, push, pop, flush_done;

  assign remaining  = WO_W'(FRAME_WORDS) - word_ofs;
  assign blen       = (32'(remaining) > 32'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(remaining);
  // Credit counts words already buffered plus words still in flight, so returns can never overflow the FIFO.
  assign credit_ok  = (SUM_W'(fifo_cnt) + SUM_W'(outstanding) + SUM_W'(blen)) <= SUM_W'(FIFO_DEPTH);
  assign issue_addr = BASE_ADDR + ADDR_W'(cur_buf) * BUF_STRIDE + ADDR_W'(word_ofs) * ADDR_W'(DATA_W / 8);
  assign accept     = (state == REQ) && !avm_waitrequest;
  assign push       = avm_readdatavalid && (state != FLUSH) && !frame_restart;
  assign pop        = out_valid && out_ready;
  assign flush_done = (state == FLUSH) && (outstanding == '0) && !frame_restart;
  assign avm_read   = (state == REQ);

  // Writer check comes first so a buffer that is both written and screenshot-locked holds the current frame.
  always_comb begin
    next_buf  = cur_buf;
    walk_buf  = cur_buf;
    walk_done = 1'b0;
    for (int k = 1; k < NUM_BUFS; k++) begin
      walk_buf = BUF_W'((32'(cur_buf) + 32'(k)) % 32'(NUM_BUFS));
      if (!walk_done) begin
        if (walk_buf == occupy_write) begin
          walk_done = 1'b1;
        end else if (walk_buf != occupy_shot) begin
          next_buf  = walk_buf;
          walk_done = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (credit_ok) state_n = REQ;
      REQ:     if (!avm_waitrequest) state_n = IDLE;
      FLUSH:   if (outstanding == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (frame_restart) state_n = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!rest_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    outstanding_n = outstanding;
    if (accept)            outstanding_n = outstanding_n + CNT_W'(avm_burstcount);
    if (avm_readdatavalid) outstanding_n = outstanding_n - CNT_W'(1);
  end

  // A burst accepted in the restart cycle still returns data, but must not move the frame position.
  always_ff @(posedge clk) begin
    if (!rest_n) begin
      word_ofs       <= '0;
      cur_buf        <= '0;
      avm_address    <= BASE_ADDR;
      avm_burstcount <= '0;
      outstanding    <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (state == IDLE && credit_ok && !frame_restart) begin
        avm_address    <= issue_addr;
        avm_burstcount <= blen;
      end
      if (accept && !frame_restart) begin
        if (word_ofs + WO_W'(avm_burstcount) == WO_W'(FRAME_WORDS)) begin
          word_ofs <= '0;
          cur_buf  <= next_buf;
        end else begin
          word_ofs <= word_ofs + WO_W'(avm_burstcount);
        end
      end
      if (flush_done) word_ofs <= '0;
    end
  end

`ifdef FRAME_READ_SOF_EN
  logic [WO_W-1:0] ret_ofs;

  always_ff @(posedge clk) begin
    if (!rest_n || flush_done) ret_ofs <= '0;
    else if (push)             ret_ofs <= (ret_ofs == WO_W'(FRAME_WORDS - 1)) ? '0 : ret_ofs + WO_W'(1);
  end

  assign push_word = {(ret_ofs == '0), avm_readdata};
  assign out_sof   = out_valid && head[DATA_W];
`else
  assign push_word = avm_readdata;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rest_n || frame_restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_frame_read_mc.sv
// tb_frame_read_mc: scoreboard bench for frame_read_mc with a behavioural Avalon burst slave and frame model.
// Define FRAME_READ_SOF_EN to also check out_sof.
module tb_frame_read_mc;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NUM_BUFS = 4;
  localparam int FRAME_WORDS = 1000;
  localparam int BURST_LEN = 128;
  localparam int FIFO_DEPTH = 512;
  localparam logic [31:0] BUF_STRIDE = 32'h0001_0000;
  localparam logic [31:0] BASE_ADDR = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rest_n, frame_restart, out_ready;
  logic [1:0]  occupy_write, occupy_shot, cur_buf;
  logic [31:0] avm_address, avm_readdata, out_data;
  logic        avm_read, avm_waitrequest, avm_readdatavalid, out_valid;
  logic [7:0]  avm_burstcount;
`ifdef FRAME_READ_SOF_EN
  logic        out_sof;
`endif

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int frames_done = 0;
  int model_buf = 0;
  int model_ofs = 0;
  int stall_left = 0;
  int stall_seen = 0;
  bit ret_hold = 1'b0;
  bit t4_pending = 1'b0;
  logic [40:0] t4_cap;
  logic [32:0] exp_q[$];
  logic [31:0] ret_q[$];

  frame_read_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BUFS(NUM_BUFS), .BUF_STRIDE(BUF_STRIDE),
    .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rest_n(rest_n), .frame_restart(frame_restart),
    .occupy_write(occupy_write), .occupy_shot(occupy_shot),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .cur_buf(cur_buf)
`ifdef FRAME_READ_SOF_EN
    , .out_sof(out_sof)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wordData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic int modelNext(input int cur, input int w, input int s);
    for (int k = 1; k < NUM_BUFS; k++) begin
      int c = (cur + k) % NUM_BUFS;
      if (c == w) return cur;
      if (c != s) return c;
    end
    return cur;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic restart, input logic [1:0] wr,
                               input logic [1:0] shot, input logic rdy);
    rest_n        = rst_n;
    frame_restart = restart;
    occupy_write  = wr;
    occupy_shot   = shot;
    out_ready     = rdy;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int c = 0;
    while (frames_done < n && c < budget) begin
      tick(1);
      c++;
    end
    if (frames_done < n) checkOutput("timeout_frames", frames_done, n);
  endtask

  // Avalon slave plus frame model: inputs change on the falling edge, the DUT samples them on the rising edge.
  initial begin
    int          exp_cnt;
    logic [31:0] exp_addr;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (!rest_n) begin
        ret_q.delete();
        exp_q.delete();
        model_buf = 0;
        model_ofs = 0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
      end else begin
        if (!ret_hold && ret_q.size() > 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = ret_q.pop_front();
        end else begin
          avm_readdatavalid = 1'b0;
        end
        if (stall_left > 0 && (avm_read || stall_seen > 0)) begin
          avm_waitrequest = 1'b1;
          if (stall_seen == 0) t4_cap = {avm_read, avm_address, avm_burstcount};
          else checkOutput("t4_hold", {avm_read, avm_address, avm_burstcount}, t4_cap);
          stall_seen++;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) begin
            accepts++;
            exp_cnt  = (FRAME_WORDS - model_ofs > BURST_LEN) ? BURST_LEN : FRAME_WORDS - model_ofs;
            exp_addr = BASE_ADDR + 32'(model_buf) * BUF_STRIDE + 32'(model_ofs) * 32'd4;
            checkOutput("burst_addr", avm_address, exp_addr);
            checkOutput("burst_len", avm_burstcount, exp_cnt);
            if (t4_pending) begin
              checkOutput("t4_accept", {avm_read, avm_address, avm_burstcount}, t4_cap);
              t4_pending = 1'b0;
            end
            for (int i = 0; i < int'(avm_burstcount); i++) ret_q.push_back(wordData(avm_address + 32'(i) * 32'd4));
            for (int i = 0; i < exp_cnt; i++)
              exp_q.push_back({((model_ofs + i) == 0), wordData(exp_addr + 32'(i) * 32'd4)});
            if (!frame_restart) begin
              model_ofs += exp_cnt;
              if (model_ofs == FRAME_WORDS) begin
                model_ofs = 0;
                model_buf = modelNext(model_buf, int'(occupy_write), int'(occupy_shot));
                frames_done++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rest_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e[31:0]);
`ifdef FRAME_READ_SOF_EN
          checkOutput("out_sof", out_sof, e[32]);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   a0;
    int   c;
    int   buf_before;
    logic flush_valid;

    applyStimulus(1'b0, 1'b0, 2'd3, 2'd1, 1'b0);
    tick(3);
    checkOutput("rst_read", avm_read, 1'b0);
    checkOutput("rst_addr", avm_address, BASE_ADDR);
    checkOutput("rst_bcount", avm_burstcount, 8'd0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_buf", cur_buf, 2'd0);

    // Stalled sink: credit must stop issuing once the FIFO plus in-flight words reach its depth.
    applyStimulus(1'b1, 1'b0, 2'd3, 2'd1, 1'b0);
    tick(400);
    checkOutput("t2_bursts", accepts, 4);
    checkOutput("t2_read_idle", avm_read, 1'b0);
    checkOutput("t2_valid", out_valid, 1'b1);

    applyStimulus(1'b1, 1'b0, 2'd3, 2'd1, 1'b1);
    waitFrames(1, 3000);
    checkOutput("t3_skip_shot", cur_buf, 2'd2);

    stall_seen = 0;
    t4_pending = 1'b1;
    stall_left = 10;
    applyStimulus(1'b1, 1'b0, 2'd1, 2'd3, 1'b1);
    waitFrames(2, 3000);
    checkOutput("t3_wrap_free", cur_buf, 2'd0);
    checkOutput("t4_stalls", stall_seen, 10);
    checkOutput("t4_accepted", t4_pending, 1'b0);

    applyStimulus(1'b1, 1'b0, 2'd2, 2'd1, 1'b1);
    waitFrames(3, 3000);
    checkOutput("t3_hold_writer", cur_buf, 2'd0);
    checkOutput("t3_model_buf", cur_buf, model_buf);

    // Restart with returns held back so a large block of data is in flight.
    tick(100);
    ret_hold = 1'b1;
    a0 = accepts;
    c = 0;
    while (accepts < a0 + 2 && c < 2000) begin
      tick(1);
      c++;
    end
    if (accepts < a0 + 2) checkOutput("timeout_t5_issue", accepts, a0 + 2);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 2'd2, 2'd1, 1'b1);
    exp_q.delete();
    model_ofs = 0;
    buf_before = model_buf;
    ret_hold = 1'b0;
    flush_valid = 1'b0;
    c = 0;
    while (ret_q.size() > 0 && c < 2000) begin
      tick(1);
      flush_valid = flush_valid | out_valid;
      c++;
    end
    checkOutput("timeout_flush", ret_q.size(), 0);
    checkOutput("t5_flush_valid", flush_valid, 1'b0);
    checkOutput("t5_same_buf", cur_buf, buf_before);
    waitFrames(4, 3000);

    // Reset in the middle of streaming.
    tick(300);
    c = 0;
    while (!avm_read && c < 500) begin
      tick(1);
      c++;
    end
    checkOutput("t6_mid_burst", avm_read, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'd3, 2'd1, 1'b1);
    tick(1);
    checkOutput("t6_rst_read", avm_read, 1'b0);
    checkOutput("t6_rst_addr", avm_address, BASE_ADDR);
    checkOutput("t6_rst_bcount", avm_burstcount, 8'd0);
    checkOutput("t6_rst_valid", out_valid, 1'b0);
    checkOutput("t6_rst_buf", cur_buf, 2'd0);
`ifdef FRAME_READ_SOF_EN
    checkOutput("t6_rst_sof", out_sof, 1'b0);
`endif
    tick(2);
    frames_done = 0;
    applyStimulus(1'b1, 1'b0, 2'd3, 2'd1, 1'b1);
    waitFrames(3, 4000);
    checkOutput("t6_post_buf", cur_buf, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
